// File: rtl/imem_uart_loader.sv
// UART (8N1) boot loader that streams a length-prefixed program into a 32-word IMEM.
// Ports: clk, rst_n, rx, start -> cpu_hold, imem_we/waddr/wdata, busy, done, frame_err, word_count.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        start,
  output logic        cpu_hold,
  output logic        imem_we,
  output logic [4:0]  imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        frame_err,
  output logic [5:0]  word_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  typedef enum logic [1:0] {L_IDLE, L_LEN, L_DATA, L_DONE} lstate_t;

  logic          rx1_q, rx2_q;
  rstate_t       rs_q, rs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          bvld_q, bvld_d;
  logic          ferr_q, ferr_d;

  lstate_t       ls_q, ls_d;
  logic [5:0]    n_q, n_d;
  logic [5:0]    wc_q, wc_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic [1:0]    bi_q, bi_d;
  logic          we_q, we_d;
  logic          fe_q, fe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx1_q  <= 1'b1;
      rx2_q  <= 1'b1;
      rs_q   <= R_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      bvld_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rx1_q  <= rx;
      rx2_q  <= rx1_q;
      rs_q   <= rs_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      bvld_q <= bvld_d;
      ferr_q <= ferr_d;
    end
  end

  always_comb begin
    rs_d   = rs_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    bvld_d = 1'b0;
    ferr_d = 1'b0;
    unique case (rs_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rx2_q) rs_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that is gone by mid-bit was a glitch.
          rs_d  = rx2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rx2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) rs_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d  = '0;
          bvld_d = rx2_q;
          ferr_d = !rx2_q;
          rs_d   = R_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_q <= L_IDLE;
      n_q  <= '0;
      wc_q <= '0;
      wa_q <= '0;
      wd_q <= '0;
      bi_q <= '0;
      we_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      ls_q <= ls_d;
      n_q  <= n_d;
      wc_q <= wc_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      bi_q <= bi_d;
      we_q <= we_d;
      fe_q <= fe_d;
    end
  end

  always_comb begin
    ls_d = ls_q;
    n_d  = n_q;
    wc_d = wc_q;
    wa_d = wa_q;
    wd_d = wd_q;
    bi_d = bi_q;
    we_d = 1'b0;
    fe_d = fe_q;
    unique case (ls_q)
      L_IDLE, L_DONE: begin
        if (start) begin
          ls_d = L_LEN;
          wc_d = '0;
          wa_d = '0;
          bi_d = '0;
          fe_d = 1'b0;
        end
      end
      L_LEN: begin
        if (ferr_q) begin
          fe_d = 1'b1;
          ls_d = L_IDLE;
        end else if (bvld_q) begin
          // Zero and anything above capacity both mean a full memory.
          n_d  = (sh_q == 8'd0 || sh_q > 8'd32) ? 6'd32 : sh_q[5:0];
          ls_d = L_DATA;
        end
      end
      L_DATA: begin
        if (we_q) begin
          wa_d = wa_q + 1'b1;
          wc_d = wc_q + 1'b1;
          if (wc_q + 6'd1 == n_q) ls_d = L_DONE;
        end
        if (ferr_q) begin
          fe_d = 1'b1;
          bi_d = '0;
          ls_d = L_IDLE;
        end else if (bvld_q) begin
          wd_d[{bi_q, 3'b000} +: 8] = sh_q;
          bi_d = bi_q + 1'b1;
          we_d = (bi_q == 2'd3);
        end
      end
      default: ls_d = L_IDLE;
    endcase
  end

  assign busy       = (ls_q == L_LEN) || (ls_q == L_DATA);
  assign cpu_hold   = busy;
  assign done       = (ls_q == L_DONE);
  assign frame_err  = fe_q;
  assign word_count = wc_q;
  assign imem_we    = we_q;
  assign imem_waddr = wa_q;
  assign imem_wdata = wd_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with CLKS_PER_BIT=4.
// Expected IMEM writes are queued as bytes are sent and checked on imem_we.
module tb_imem_uart_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        start = 1'b0;
  logic        cpu_hold, imem_we, busy, done, frame_err;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [5:0]  word_count;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic [36:0] exp_q[$];

  imem_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .start(start),
    .cpu_hold(cpu_hold), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .frame_err(frame_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      logic [36:0] e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", {27'd0, imem_waddr}, {27'd0, e[36:32]});
        chk("we_data", imem_wdata, e[31:0]);
        chk("we_busy", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({pfx, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({pfx, "_waddr"}, {27'd0, imem_waddr}, 32'd0);
    chk({pfx, "_wdata"}, imem_wdata, 32'd0);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    chk({pfx, "_done"}, {31'd0, done}, 32'd0);
    chk({pfx, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({pfx, "_wc"}, {26'd0, word_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int base;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Two-word load.
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'd2);
    exp_q.push_back({5'd0, 32'h0000_0013});
    exp_q.push_back({5'd1, 32'h0010_0093});
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_wrs", wr_cnt, 32'd2);
    chk("t1_wc", {26'd0, word_count}, 32'd2);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_hold_off", {31'd0, cpu_hold}, 32'd0);

    // Bytes in DONE are dropped.
    send_word(32'hDEAD_BEEF);
    chk("done_drop", wr_cnt, 32'd2);
    chk("done_wc", {26'd0, word_count}, 32'd2);

    // N=0 means a full 32-word load.
    base = wr_cnt;
    pulse_start();
    chk("t2_wc_clr", {26'd0, word_count}, 32'd0);
    send_byte(8'd0);
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      exp_q.push_back({5'(i), w});
      send_word(w);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("t2_wrs", wr_cnt - base, 32'd32);
    chk("t2_wc", {26'd0, word_count}, 32'd32);
    chk("t2_done", {31'd0, done}, 32'd1);

    // Frame error in the sixth byte of a three-word load.
    base = wr_cnt;
    pulse_start();
    send_byte(8'd3);
    exp_q.push_back({5'd0, 32'h4433_2211});
    send_word(32'h4433_2211);
    send_byte(8'h55);
    send_byte(8'h66, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_ferr", {31'd0, frame_err}, 32'd1);
    chk("t3_done", {31'd0, done}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    chk("t3_wrs", wr_cnt - base, 32'd1);
    chk("t3_wc", {26'd0, word_count}, 32'd1);

    // One-cycle glitch and stray bytes in IDLE.
    base = wr_cnt;
    @(posedge clk);
    rx = 1'b0;
    @(posedge clk);
    rx = 1'b1;
    repeat (6 * CPB) @(posedge clk);
    #1;
    chk("t4_glitch_busy", {31'd0, busy}, 32'd0);
    send_byte(8'd1);
    send_word(32'h0102_0304);
    send_byte(8'h00, 1'b0);
    #1;
    chk("t4_wrs", wr_cnt - base, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_ferr_kept", {31'd0, frame_err}, 32'd1);

    // start while busy is ignored.
    base = wr_cnt;
    pulse_start();
    chk("t5_ferr_clr", {31'd0, frame_err}, 32'd0);
    send_byte(8'd2);
    exp_q.push_back({5'd0, 32'hCAFE_0001});
    exp_q.push_back({5'd1, 32'hCAFE_0002});
    send_word(32'hCAFE_0001);
    chk("t5_wc1", {26'd0, word_count}, 32'd1);
    pulse_start();
    chk("t5_wc_kept", {26'd0, word_count}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    send_word(32'hCAFE_0002);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_wc2", {26'd0, word_count}, 32'd2);
    chk("t5_done", {31'd0, done}, 32'd1);
    chk("t5_wrs", wr_cnt - base, 32'd2);

    // Reset in the middle of a word.
    base = wr_cnt;
    pulse_start();
    send_byte(8'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6");
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_word(32'h1234_5678);
    #1;
    chk("t6_wrs", wr_cnt - base, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("end_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200); legal values >= 4.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx  input  1  UART serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port cpu_hold  output  1  high while loading; drives the CPU's reset.
REQ-007 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 SHALL have port imem_waddr  output  5  instruction-memory word address (32 words).
REQ-009 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-010 SHALL have port busy  output  1  high in states LEN and DATA.
REQ-011 SHALL have port done  output  1  high in state DONE.
REQ-012 SHALL have port frame_err  output  1  sticky; set on a bad stop bit during a load.
REQ-013 SHALL have port word_count  output  6  words written in the current or most recent load (0..32).

Function
REQ-014 SHALL synchronize rx through two flip-flops before any use.
REQ-015 SHALL use a UART receiver with states R_IDLE, R_START, R_DATA, R_STOP; format 8N1, LSB first.
REQ-016 R_IDLE -> R_START on synchronized rx = 0; wait CLKS_PER_BIT/2 cycles, then resample: 0 -> R_DATA, 1 -> R_IDLE (glitch rejected, no byte).
REQ-017 R_DATA SHALL sample 8 bits, each CLKS_PER_BIT cycles after the previous sample.
REQ-018 R_STOP SHALL sample once after CLKS_PER_BIT cycles: 1 -> byte_valid pulse (1 cycle); 0 -> frame-error pulse, byte discarded; then R_IDLE.
REQ-019 SHALL use a loader FSM with states IDLE, LEN, DATA, DONE.
REQ-020 IDLE or DONE with start=1 -> LEN; clear word_count, byte index, imem_waddr, and frame_err.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 LEN: first valid byte is word total N; N=0 means 32; N>32 saturates to 32; -> DATA.
REQ-023 DATA: bytes SHALL be assembled little-endian (1st byte -> imem_wdata[7:0], 4th -> [31:24]).
REQ-024 On the 4th byte, imem_we SHALL pulse high one cycle later with imem_wdata and imem_waddr stable for that cycle.
REQ-025 After each write, imem_waddr and word_count SHALL increment by 1; imem_waddr wraps 31 -> 0 but is unused after the last word.
REQ-026 When word_count reaches N, the FSM SHALL go DATA -> DONE in the cycle after the final imem_we.
REQ-027 cpu_hold SHALL be 1 in LEN and DATA and 0 in IDLE and DONE; it falls in the same cycle busy falls.
REQ-028 A frame error in LEN or DATA SHALL set frame_err, discard any partial word, and go to IDLE (no done); a frame error in IDLE or DONE SHALL be ignored.
REQ-029 Bytes received in IDLE or DONE SHALL be dropped with no memory write.
REQ-030 imem_we SHALL never be high outside DATA or the cycle of the transition to DONE.

Reset
REQ-031 rst_n=0 SHALL asynchronously force both FSMs to idle, the synchronizer to 1, and these outputs: cpu_hold=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, frame_err=0, word_count=0.
REQ-032 Reset asserted mid-load SHALL abort the load with no further imem_we; after release the block waits in IDLE for start.

Verification (CLKS_PER_BIT=4)
REQ-033 Reset test: start=1, send N=2, then bytes 13 00 00 00 93 00 10 00 -> imem_we twice: addr 0 data 0x00000013, addr 1 data 0x00100093; word_count=2; done=1; cpu_hold 1 -> 0.
REQ-034 Reset test: N=0, send 128 bytes -> 32 writes at addresses 0..31; word_count=32; done=1.
REQ-035 Reset test: start, N=3, 5 bytes, 6th byte with stop bit 0 -> frame_err=1; done=0; busy=0; exactly one imem_we, at addr 0.
REQ-036 Reset test: rx low for 1 cycle, then bytes in IDLE -> no byte, no imem_we; busy=0.
REQ-037 Reset test: start while busy -> ignored; word_count is not cleared.
REQ-038 Reset test: rst_n low mid-word -> all outputs at reset values immediately; no imem_we after rst_n rises.
